// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/state types, GF(2^8) xtime, column count and
// the (column,row) -> byte-lane index helper used by the round stages.
package aes_pkg;

  localparam int unsigned AES_NB      = 4;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_COL_W   = 32;
  localparam int unsigned AES_STATE_W = 128;

  typedef logic [AES_BYTE_W-1:0]  aes_byte_t;
  typedef logic [AES_COL_W-1:0]   aes_col_t;
  // Byte i lives at bits [i*8 +: 8]; byte 0 is the leftmost byte of a literal.
  typedef logic [0:AES_STATE_W-1] aes_state_t;

  // Multiply by {02} in GF(2^8) with the AES reduction polynomial.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte lane of FIPS-197 column col, row row.
  function automatic int unsigned aes_idx(input int unsigned col, input int unsigned row);
    return AES_NB * col + row;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// MixColumns on one 32-bit column (row 0 in bits [31:24]); purely combinational.
// Ports: col_in  - column after ShiftRows
//        col_out_c - mixed column
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  output logic [AES_COL_W-1:0] col_out_c
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t x0, x1, x2, x3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // Rows of the circulant {02 03 01 01}; {03}*a = xtime(a) ^ a.
  assign col_out_c[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out_c[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out_c[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out_c[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/aes_mix_round_stage.sv
// Registered AES round back-end: out = AddRoundKey(MixColumns(ShiftRows(in))),
// with MixColumns bypassed when in_last is set. Valid/ready on both sides.
// Optional macro AES_MIX_SKID_EN adds a 1-entry skid after the output register
// so in_ready is registered; without it in_ready = !out_valid || out_ready.
// Ports: clk, rst_n (sync, active-low)
//        in_valid/in_ready/in_data/in_key/in_last - SubBytes-side beat
//        out_valid/out_ready/out_data             - round result
module aes_mix_round_stage
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_STATE_W-1] in_data,
  input  logic [0:AES_STATE_W-1] in_key,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_STATE_W-1] out_data
);

  aes_state_t sr_c;
  aes_state_t mc_c;
  aes_state_t result_c;
  logic       in_fire;

  // ShiftRows: out (c,r) takes in ((c+r) mod 4, r).
  for (genvar c = 0; c < AES_NB; c++) begin : g_sr_col
    for (genvar r = 0; r < AES_NB; r++) begin : g_sr_row
      assign sr_c[aes_idx(c, r)*AES_BYTE_W +: AES_BYTE_W] =
        in_data[aes_idx((c + r) % AES_NB, r)*AES_BYTE_W +: AES_BYTE_W];
    end
  end

  // MixColumns, one instance per column.
  for (genvar c = 0; c < AES_NB; c++) begin : g_mix
    aes_mix_column u_mix (
      .col_in    (sr_c[c*AES_COL_W +: AES_COL_W]),
      .col_out_c (mc_c[c*AES_COL_W +: AES_COL_W])
    );
  end

  assign result_c = (in_last ? sr_c : mc_c) ^ in_key;

`ifdef AES_MIX_SKID_EN
  logic       skid_valid;
  aes_state_t skid_data;
  logic       out_free;

  // skid_valid is a flop, so in_ready carries no path from out_ready.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Output register refills from the skid first, then from the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= result_c;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= result_c;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Single output register; a push may coincide with a pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= result_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_mix_round_stage.sv
// Directed self-checking bench for aes_mix_round_stage.
module tb_aes_mix_round_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic [0:127] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;

  int total = 0;
  int bad   = 0;

  aes_mix_round_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Uniform-byte state: ShiftRows and MixColumns both leave it unchanged.
  function automatic logic [0:127] beat(input int i);
    logic [7:0] b;
    b = 8'(8'h10 + i);
    return {16{b}};
  endfunction

  // Drive one beat with out_ready high, then check the registered result.
  task automatic one_beat(input string tag, input logic [0:127] d, input logic [0:127] k,
                          input logic l, input logic [0:127] exp);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_key    = k;
    in_last   = l;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk(tag, out_data, exp);
  endtask

  initial begin
    int         sent;
    int         recv;
    int         cyc;
    int         acc;
    logic       prev_stall;
    logic [0:127] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;

    // FIPS-197 App. B round 1; input is the SubBytes state in column-major byte order.
    one_beat("fips_round1",
             128'hd42711ae_e0bf98f1_b8b45de5_1e415230,
             128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0,
             128'ha49c7ff2_689f352b_6b5bea43_026a5049);

    // Final-round bypass, zero key.
    one_beat("last_bypass",
             128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b1,
             128'h00050a0f_04090e03_080d0207_0c01060b);

    // Final-round bypass with all-ones key.
    one_beat("last_key",
             128'h00010203_04050607_08090a0b_0c0d0e0f, {128{1'b1}}, 1'b1,
             128'hfffaf5f0_fbf6f1fc_f7f2fdf8_f3fef9f4);

    // MixColumns vector db135345 -> 8e4da1bc; bytes sit on the ShiftRows
    // diagonal so they land together in column 0.
    one_beat("mix_col0",
             128'hdb000000_00130000_00005300_00000045, 128'h0, 1'b0,
             128'h8e4da1bc_00000000_00000000_00000000);

    // Drain
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_empty", 128'(out_valid), 128'(0));

    // Backpressure stream: 8 beats, out_ready pattern 1,0,0,1
    sent       = 0;
    recv       = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    held       = '0;
    while (recv < 8 && cyc < 64) begin
      @(negedge clk);
      if (prev_stall) chk("stall_hold", out_data, held);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      in_data   = beat(sent);
      in_key    = '0;
      in_last   = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        chk("stream_data", out_data, beat(recv));
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      held       = out_data;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_recv", 128'(recv), 128'(8));
    chk("stream_sent", 128'(sent), 128'(8));
    out_ready = 1'b1;
    @(negedge clk);
    chk("stream_no_dup", 128'(out_valid), 128'(0));

    // Beats absorbed while the output is stalled from empty
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = beat(20 + i);
      #1;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
`ifdef AES_MIX_SKID_EN
    chk("stall_absorb", 128'(acc), 128'(2));
`else
    chk("stall_absorb", 128'(acc), 128'(1));
`endif
    chk("stall_head", out_data, beat(20));

    // Reset for one cycle with held beats; they must never appear
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_emit", 128'(out_valid), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
